// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register file write port, with a saturating conflict counter.
// Optional macro REGFILE_ARB_R0_ZERO_EN makes register 0 read-only zero and adds the r0_drop output.
module regfile_write_arbiter #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arb_en,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
`ifdef REGFILE_ARB_R0_ZERO_EN
    output logic          r0_drop,
`endif
    output logic [CW-1:0] conflict_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          r_prio;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_conflict;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
`ifdef REGFILE_ARB_R0_ZERO_EN
    logic          r_r0_drop;
`endif

    // Grant decode: looks only at requests, enable and pointer; silent while in reset
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_conflict = 1'b0;
        if (rst || !arb_en) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (req0 && req1) begin
            w_conflict = 1'b1;
            w_gnt0     = ~r_prio;
            w_gnt1     = r_prio;
        end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
        end
    end

    // Winner's address/data mux feeding the output register
    always_comb begin
        w_sel_addr = addr0;
        w_sel_data = data0;
        if (w_gnt1) begin
            w_sel_addr = addr1;
            w_sel_data = data1;
        end else begin
            w_sel_addr = addr0;
            w_sel_data = data0;
        end
    end

    // Write-port register, priority pointer and r0 drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= {AW{1'b0}};
            r_wdata <= {DW{1'b0}};
`ifdef REGFILE_ARB_R0_ZERO_EN
            r_r0_drop <= 1'b0;
`endif
        end else if (w_gnt0 || w_gnt1) begin
            // Loser of this transfer gets priority next time
            r_prio <= w_gnt0;
`ifdef REGFILE_ARB_R0_ZERO_EN
            if (w_sel_addr == {AW{1'b0}}) begin
                r_we      <= 1'b0;
                r_r0_drop <= 1'b1;
            end else begin
                r_we      <= 1'b1;
                r_r0_drop <= 1'b0;
                r_waddr   <= w_sel_addr;
                r_wdata   <= w_sel_data;
            end
`else
            r_we    <= 1'b1;
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
`endif
        end else begin
            r_we <= 1'b0;
`ifdef REGFILE_ARB_R0_ZERO_EN
            r_r0_drop <= 1'b0;
`endif
        end
    end

    // Saturating count of contended, enabled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_conflict && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign gnt0         = w_gnt0;
    assign gnt1         = w_gnt1;
    assign rf_we        = r_we;
    assign rf_waddr     = r_waddr;
    assign rf_wdata     = r_wdata;
    assign conflict_cnt = r_cnt;
`ifdef REGFILE_ARB_R0_ZERO_EN
    assign r0_drop      = r_r0_drop;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle comparison against a behavioural model plus directed literal checks.
// Uses a narrow conflict counter so saturation is reachable in a short run.
module tb_regfile_write_arbiter;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arb_en = 1'b0;
    logic          req0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] data0 = '0;
    logic          gnt0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] data1 = '0;
    logic          gnt1;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [CW-1:0] conflict_cnt;
`ifdef REGFILE_ARB_R0_ZERO_EN
    logic          r0_drop;
`endif

    regfile_write_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef REGFILE_ARB_R0_ZERO_EN
        .r0_drop(r0_drop),
`endif
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_on  = 1'b0;

    // Register file attached to the write port, used for readback
    logic [DW-1:0] rf_mem [0:(1<<AW)-1];
    initial for (int k = 0; k < (1 << AW); k++) rf_mem[k] = '0;
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Behavioural model
    int m_prio = 0, m_we = 0, m_waddr = 0, m_wdata = 0, m_cnt = 0, m_drop = 0;

    function automatic int winner();
        if (rst || !arb_en) return -1;
        if (req0 && req1) return m_prio;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prio = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_drop = 0;
        end else begin
            int w, a, d;
            w = winner();
            m_drop = 0;
            if (arb_en && req0 && req1 && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (w < 0) begin
                m_we = 0;
            end else begin
                a = (w == 1) ? int'(addr1) : int'(addr0);
                d = (w == 1) ? int'(data1) : int'(data0);
                m_prio = 1 - w;
`ifdef REGFILE_ARB_R0_ZERO_EN
                if (a == 0) begin m_we = 0; m_drop = 1; end
                else begin m_we = 1; m_waddr = a; m_wdata = d; end
`else
                m_we = 1; m_waddr = a; m_wdata = d;
`endif
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_gnt0", int'(gnt0), int'(winner() == 0));
            chk("model_gnt1", int'(gnt1), int'(winner() == 1));
            chk("model_rf_we", int'(rf_we), m_we);
            chk("model_rf_waddr", int'(rf_waddr), m_waddr);
            chk("model_rf_wdata", int'(rf_wdata), m_wdata);
            chk("model_conflict_cnt", int'(conflict_cnt), m_cnt);
`ifdef REGFILE_ARB_R0_ZERO_EN
            chk("model_r0_drop", int'(r0_drop), m_drop);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        cmp_on = 1'b1;
        chk("reset_rf_we", int'(rf_we), 0);
        chk("reset_rf_waddr", int'(rf_waddr), 0);
        chk("reset_rf_wdata", int'(rf_wdata), 0);
        chk("reset_cnt", int'(conflict_cnt), 0);
        rst = 1'b0; arb_en = 1'b1;

        // Single requester
        req0 = 1'b1; addr0 = 3'd3; data0 = 8'h0D;
        @(negedge clk); chk("single_gnt0", int'(gnt0), 1); chk("single_gnt1", int'(gnt1), 0);
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("single_we", int'(rf_we), 1); chk("single_waddr", int'(rf_waddr), 3); chk("single_wdata", int'(rf_wdata), 8'h0D);
        tick();
        @(negedge clk); chk("single_we_off", int'(rf_we), 0); chk("single_waddr_hold", int'(rf_waddr), 3);

        // Sustained contention from reset
        do_reset();
        req0 = 1'b1; addr0 = 3'd1; data0 = 8'hA1;
        req1 = 1'b1; addr1 = 3'd2; data1 = 8'hB2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("cont_gnt0", int'(gnt0), (i % 2 == 0) ? 1 : 0);
                chk("cont_gnt1", int'(gnt1), (i % 2 == 1) ? 1 : 0);
            end
            if (i > 0) begin
                chk("cont_we", int'(rf_we), 1);
                chk("cont_wdata", int'(rf_wdata), (i % 2 == 1) ? 8'hA1 : 8'hB2);
            end
            if (i == 4) chk("cont_cnt", int'(conflict_cnt), 4);
            tick();
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end

        // Same-address collision
        do_reset();
        req0 = 1'b1; addr0 = 3'd5; data0 = 8'h11;
        req1 = 1'b1; addr1 = 3'd5; data1 = 8'h22;
        @(negedge clk); chk("coll_gnt0", int'(gnt0), 1);
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("coll_gnt1", int'(gnt1), 1); chk("coll_waddr1", int'(rf_waddr), 5); chk("coll_wdata1", int'(rf_wdata), 8'h11);
        tick(); req1 = 1'b0;
        @(negedge clk); chk("coll_waddr2", int'(rf_waddr), 5); chk("coll_wdata2", int'(rf_wdata), 8'h22);
        tick();
        @(negedge clk); chk("coll_readback", int'(rf_mem[5]), 8'h22);

        // Enable gating, with a write in flight when enable drops
        req0 = 1'b1; addr0 = 3'd4; data0 = 8'h44;
        @(negedge clk); chk("gate_pre_gnt0", int'(gnt0), 1);
        tick();
        arb_en = 1'b0;
        req0 = 1'b1; addr0 = 3'd1; data0 = 8'h61;
        req1 = 1'b1; addr1 = 3'd6; data1 = 8'h66;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("gate_gnt0", int'(gnt0), 0); chk("gate_gnt1", int'(gnt1), 0);
            chk("gate_cnt", int'(conflict_cnt), 1);
            chk("gate_we", int'(rf_we), (j == 0) ? 1 : 0);
            if (j == 0) chk("gate_inflight_wdata", int'(rf_wdata), 8'h44);
            tick();
        end
        arb_en = 1'b1;
        @(negedge clk); chk("resume_gnt1", int'(gnt1), 1); chk("resume_gnt0", int'(gnt0), 0);
        tick();

        // Asynchronous reset while a write is on the port
        #2 rst = 1'b1;
        #1;
        chk("areset_we", int'(rf_we), 0); chk("areset_gnt0", int'(gnt0), 0);
        chk("areset_gnt1", int'(gnt1), 0); chk("areset_cnt", int'(conflict_cnt), 0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("post_reset_gnt0", int'(gnt0), 1); chk("post_reset_gnt1", int'(gnt1), 0);

        // Counter saturation
        repeat (20) tick();
        @(negedge clk); chk("sat_cnt", int'(conflict_cnt), CMAX);
        tick(); req0 = 1'b0; req1 = 1'b0;
        tick();

        // Address 0 write
        req1 = 1'b1; addr1 = 3'd0; data1 = 8'hFF;
        @(negedge clk); chk("r0_gnt1", int'(gnt1), 1);
        tick(); req1 = 1'b0;
        @(negedge clk);
`ifdef REGFILE_ARB_R0_ZERO_EN
        chk("r0_we", int'(rf_we), 0); chk("r0_drop", int'(r0_drop), 1);
`else
        chk("r0_we", int'(rf_we), 1); chk("r0_waddr", int'(rf_waddr), 0); chk("r0_wdata", int'(rf_wdata), 8'hFF);
`endif
        tick();
        @(negedge clk);
`ifdef REGFILE_ARB_R0_ZERO_EN
        chk("r0_drop_off", int'(r0_drop), 0); chk("r0_readback", int'(rf_mem[0]), 8'h00);
`else
        chk("r0_readback", int'(rf_mem[0]), 8'hFF);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
